// File: rtl/binary_counter.sv
// rtl/binary_counter.sv - up-counter with parallel load, enable, carry pulse and wrap-event count
module binary_counter #(
  parameter int WIDTH  = 4,
  parameter int AWIDTH = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              Enable,
  input  logic              Load,
  input  logic [WIDTH-1:0]  Data_in,
  output logic [WIDTH-1:0]  Count,
  output logic [AWIDTH-1:0] A_count,
  output logic              C_out
);

  localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
  localparam logic [AWIDTH-1:0] WRAP_ONE = AWIDTH'(1);

  logic [WIDTH-1:0]  count_q, count_d;
  logic [AWIDTH-1:0] a_count_q, a_count_d;
  logic              c_out_q, c_out_d;

  // Next-state selection: Load beats Enable; carry is only raised by a counted wrap, never by a load.
  always_comb begin
    count_d   = count_q;
    a_count_d = a_count_q;
    c_out_d   = 1'b0;
    if (Load) begin
      count_d = Data_in;
    end else if (Enable) begin
      if (count_q == CNT_MAX) begin
        count_d   = '0;
        c_out_d   = 1'b1;
        a_count_d = a_count_q + WRAP_ONE;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end
  end

  // State registers with synchronous active-high reset overriding everything.
  always_ff @(posedge CLK) begin
    if (reset) begin
      count_q   <= '0;
      a_count_q <= '0;
      c_out_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      a_count_q <= a_count_d;
      c_out_q   <= c_out_d;
    end
  end

  assign Count   = count_q;
  assign A_count = a_count_q;
  assign C_out   = c_out_q;

endmodule

// File: tb/tb_binary_counter.sv
// tb/tb_binary_counter.sv - scoreboard bench for binary_counter
module tb_binary_counter;

  logic       CLK;
  logic       reset;
  logic       Enable;
  logic       Load;
  logic [3:0] Data_in;
  logic [3:0] Count;
  logic [3:0] A_count;
  logic       C_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] cnt;
    logic [3:0] ac;
    logic       c;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  logic [3:0] m_cnt;
  logic [3:0] m_ac;
  logic       m_c;

  binary_counter #(.WIDTH(4), .AWIDTH(4)) dut (
    .CLK     (CLK),
    .reset   (reset),
    .Enable  (Enable),
    .Load    (Load),
    .Data_in (Data_in),
    .Count   (Count),
    .A_count (A_count),
    .C_out   (C_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 8'd0, 8'd1);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_count"}, {4'h0, Count}, {4'h0, e.cnt});
      chk({e.tag, "_acount"}, {4'h0, A_count}, {4'h0, e.ac});
      chk({e.tag, "_cout"}, {7'h0, C_out}, {7'h0, e.c});
    end
  endtask

  task automatic step(input logic r, input logic en, input logic ld,
                      input logic [3:0] d, input string tag);
    exp_t e;
    @(negedge CLK);
    reset   = r;
    Enable  = en;
    Load    = ld;
    Data_in = d;
    if (r) begin
      m_cnt = 4'h0; m_ac = 4'h0; m_c = 1'b0;
    end else if (ld) begin
      m_cnt = d; m_c = 1'b0;
    end else if (en) begin
      if (m_cnt == 4'hF) begin
        m_cnt = 4'h0; m_c = 1'b1; m_ac = m_ac + 4'h1;
      end else begin
        m_cnt = m_cnt + 4'h1; m_c = 1'b0;
      end
    end else begin
      m_c = 1'b0;
    end
    e.cnt = m_cnt; e.ac = m_ac; e.c = m_c; e.tag = tag;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    check_out();
  endtask

  initial begin
    int pulses;
    int last_pulse;
    reset = 1'b0; Enable = 1'b0; Load = 1'b0; Data_in = 4'h0;
    m_cnt = 4'h0; m_ac = 4'h0; m_c = 1'b0;

    // reset held with Load/Enable active
    step(1, 1, 1, 4'hA, "rst0");
    step(1, 1, 1, 4'hA, "rst1");
    chk("rst_count_zero", {4'h0, Count}, 8'h00);
    step(0, 1, 0, 4'hA, "run1");
    chk("run_count1", {4'h0, Count}, 8'h01);
    step(0, 1, 0, 4'hA, "run2");
    step(0, 1, 0, 4'hA, "run3");
    chk("run_count3", {4'h0, Count}, 8'h03);

    // load priority over enable
    step(0, 1, 1, 4'h7, "ld7");
    chk("ld_count7", {4'h0, Count}, 8'h07);
    step(0, 1, 0, 4'h0, "inc8");
    chk("inc_count8", {4'h0, Count}, 8'h08);

    // wrap and carry from a clean A_count
    step(1, 0, 0, 4'h0, "rst_w");
    step(0, 0, 1, 4'hE, "ldE");
    step(0, 1, 0, 4'h0, "wF");
    chk("wF_cout", {7'h0, C_out}, 8'h00);
    step(0, 1, 0, 4'h0, "w0");
    chk("w0_cout", {7'h0, C_out}, 8'h01);
    chk("w0_acount", {4'h0, A_count}, 8'h01);
    step(0, 1, 0, 4'h0, "w1");
    chk("w1_cout", {7'h0, C_out}, 8'h00);

    // loading the max value must not raise carry
    step(0, 1, 1, 4'hF, "ldF");
    chk("ldF_cout", {7'h0, C_out}, 8'h00);

    // hold
    step(0, 0, 1, 4'h5, "ld5");
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 4'h0, "hold");
      chk("hold_count5", {4'h0, Count}, 8'h05);
    end

    // A_count wrap over 256 enabled cycles from reset
    step(1, 0, 0, 4'h0, "rst_a");
    pulses = 0;
    last_pulse = 0;
    for (int i = 1; i <= 256; i++) begin
      step(0, 1, 0, 4'h0, "long");
      if (C_out === 1'b1) begin
        pulses++;
        chk("pulse_cycle", 8'(i % 16), 8'h00);
        if (pulses > 1) chk("pulse_spacing", 8'(i - last_pulse), 8'd16);
        last_pulse = i;
      end
      if (i == 255) chk("acount_pre_wrap", {4'h0, A_count}, 8'h0F);
    end
    chk("pulse_total", 8'(pulses), 8'd16);
    chk("acount_post_wrap", {4'h0, A_count}, 8'h00);

    // synchronous reset mid-count
    step(0, 0, 1, 4'h8, "ld8");
    step(0, 1, 0, 4'h0, "to9");
    chk("mid_count9", {4'h0, Count}, 8'h09);
    @(negedge CLK);
    reset = 1'b1;
    #2;
    chk("no_async_clear", {4'h0, Count}, 8'h09);
    step(1, 1, 0, 4'h0, "mid_rst");
    chk("mid_rst_acount", {4'h0, A_count}, 8'h00);
    step(0, 1, 0, 4'h0, "resume");
    chk("resume_count1", {4'h0, Count}, 8'h01);

    chk("scoreboard_drained", 8'(sb_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/binary_counter.md
Name: binary_counter

Overview:
- Synchronous up-counter with parallel load and enable.
- Produces a registered carry-out pulse on every wrap-around and keeps an auxiliary count of wrap events.
- Leaf datapath block; driven and observed through apb_interface in the counter verification environment.
- All outputs are registered; no combinational paths from inputs to outputs.

Parameters:
- WIDTH, 4, width of Data_in and Count.
- AWIDTH, 4, width of the wrap-event counter A_count.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Enable  input  1  count-enable; increments Count when high and Load is low.
- Load  input  1  parallel-load strobe; has priority over Enable.
- Data_in  input  WIDTH  value loaded into Count when Load is high.
- Count  output  WIDTH  main counter value.
- A_count  output  AWIDTH  number of Count wrap-arounds (max to 0) since reset, modulo 2^AWIDTH.
- C_out  output  1  carry-out pulse, high for exactly one cycle after a wrap.

Behaviour:
- One clock domain (CLK). Reset is synchronous and active-high: sampled only on the rising edge of CLK; no asynchronous path.
- Reset (reset=1 at the edge):
  - Count=0, A_count=0, C_out=0 after that edge.
  - Overrides Load and Enable.
- Priority per edge: reset > Load > Enable > hold.
- Load=1 (reset=0):
  - Count<=Data_in and C_out<=0; A_count unchanged.
  - Enable is ignored that cycle.
  - Loading 2^WIDTH-1 does not assert C_out.
- Enable=1, Load=0, reset=0:
  - If Count<2^WIDTH-1: Count<=Count+1, C_out<=0, A_count unchanged.
  - If Count==2^WIDTH-1: Count<=0, C_out<=1, A_count<=A_count+1 (modulo 2^AWIDTH; wraps from 2^AWIDTH-1 to 0, no saturation).
- Enable=0, Load=0, reset=0: Count and A_count hold, C_out<=0.
- C_out timing:
  - Registered; asserted in the cycle immediately following the edge on which Count wrapped to 0.
  - Never high for more than one cycle per wrap.
  - Continuous Enable gives one C_out pulse every 2^WIDTH cycles.
- Latency: one cycle from input sampled at an edge to output change. Count reflects Data_in on the cycle after Load.
- Reset mid-count: the next edge with reset=1 clears all outputs regardless of Enable/Load; counting resumes from 0 on the first edge with reset=0 and Enable=1.
- Power-up values before the first reset are undefined; the bench must apply reset before checking.
- Arithmetic is unsigned; Data_in is used as-is with no extension or truncation.

Test Plan:
- Reset: hold reset=1 for 2 cycles with Enable=1, Load=1, Data_in=4'hA -> Count=0, A_count=0, C_out=0 throughout; after release with Enable=1 -> Count=1, 2, 3 on successive cycles.
- Load priority: Load=1, Enable=1, Data_in=4'h7 for one cycle -> Count=7, C_out=0; then Load=0, Enable=1 -> Count=8.
- Wrap and carry: load 4'hE, then Enable=1 for 3 cycles -> Count=F, 0, 1; C_out=1 only in the cycle where Count=0; A_count increments 0->1.
- Hold: Count=5, Enable=0, Load=0 for 4 cycles -> Count stays 5, C_out=0, A_count unchanged.
- A_count wrap: Enable=1 continuously for 16*16 cycles from reset -> 16 C_out pulses, each 16 cycles apart; A_count reads 15 before the 16th wrap and 0 after it.
- Synchronous reset mid-operation: reset=1 for one edge while Count=9, Enable=1 -> Count=0, A_count=0 at that edge, with no asynchronous change between edges; counting resumes at 1 on the next edge.
